// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode, funct, ALUOp and ALUCtl encodings shared by the control unit and the ALU
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b100;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps (alu_op, funct) to the 3-bit ALU control code; unknown funct falls back to add
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);
  always_comb
    alu_ctl = alu_op == ALUOP_SUB ? ALUCTL_SUB :
              alu_op != ALUOP_FUNCT ? ALUCTL_ADD :
              funct == FUNCT_SUB ? ALUCTL_SUB :
              funct == FUNCT_AND ? ALUCTL_AND :
              funct == FUNCT_OR  ? ALUCTL_OR  :
              funct == FUNCT_SLT ? ALUCTL_SLT : ALUCTL_ADD;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM of the multicycle MIPS core
// ports: clk/reset, Op/Funct from IR, Zero from ALU; mux selects, ALUCtl, write enables, PCEn, illegal_op
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op
);
  state_t state, next;
  logic [3:0] cnt;
  logic is_lw, pc_write, branch;
  logic [1:0] alu_op;
  wire mem_st = state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  wire last = cnt == 4'(MEM_LATENCY - 1);
  // lw/sw is captured in DECODE so MEMADR ignores later changes on Op
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_FETCH;
      cnt <= '0;
      is_lw <= 1'b0;
    end else begin
      cnt <= mem_st && !last ? cnt + 4'd1 : '0;
      state <= mem_st && !last ? state : next;
      if (state == S_DECODE) is_lw <= Op == OP_LW;
    end
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:   next = S_DECODE;
      S_DECODE:  next = Op == OP_LW || Op == OP_SW ? S_MEMADR :
                        Op == OP_RTYPE ? S_EXECUTE :
                        Op == OP_BEQ ? S_BRANCH :
                        Op == OP_ADDI ? S_ADDIEX :
                        Op == OP_J ? S_JUMP : S_FETCH;
      S_MEMADR:  next = is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: next = S_MEMWB;
      S_EXECUTE: next = S_ALUWB;
      S_ADDIEX:  next = S_ADDIWB;
      default:   next = S_FETCH;
    endcase
  end
  // all outputs stay at their zero defaults while reset is held
  always_comb begin
    {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, pc_write, branch, illegal_op} = '0;
    ALUSrcB = 2'b00;
    PCSrc = 2'b00;
    alu_op = ALUOP_ADD;
    if (!reset)
      case (state)
        S_FETCH: begin
          ALUSrcB = 2'b01;
          IRWrite = last;
          pc_write = last;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          illegal_op = next == S_FETCH;
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMREAD: IorD = 1'b1;
        S_MEMWRITE: begin
          IorD = 1'b1;
          MemWrite = last;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          alu_op = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst = 1'b1;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          alu_op = ALUOP_SUB;
          PCSrc = 2'b01;
          branch = 1'b1;
        end
        S_JUMP: begin
          PCSrc = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
  end
  assign PCEn = pc_write | (branch & Zero);
  alu_decoder u_dec (.alu_op(alu_op), .funct(Funct), .alu_ctl(ALUCtl));
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench over three instances with MEM_LATENCY 1, 2, 3
module tb_mips_multicycle_ctrl;
  localparam logic [15:0] ZERO   = 16'b0_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] F_W    = 16'b0_0_0_0_0_0_0_01_000_00_0_0;
  localparam logic [15:0] F_L    = 16'b0_0_1_0_0_0_0_01_000_00_1_0;
  localparam logic [15:0] DEC    = 16'b0_0_0_0_0_0_0_11_000_00_0_0;
  localparam logic [15:0] DEC_IL = 16'b0_0_0_0_0_0_0_11_000_00_0_1;
  localparam logic [15:0] MA     = 16'b0_0_0_0_0_0_1_10_000_00_0_0;
  localparam logic [15:0] MR     = 16'b1_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] MW_W   = 16'b1_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] MW_L   = 16'b1_1_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] MWB    = 16'b0_0_0_0_1_1_0_00_000_00_0_0;
  localparam logic [15:0] EX_ADD = 16'b0_0_0_0_0_0_1_00_000_00_0_0;
  localparam logic [15:0] EX_SUB = 16'b0_0_0_0_0_0_1_00_001_00_0_0;
  localparam logic [15:0] EX_OR  = 16'b0_0_0_0_0_0_1_00_011_00_0_0;
  localparam logic [15:0] EX_SLT = 16'b0_0_0_0_0_0_1_00_100_00_0_0;
  localparam logic [15:0] ALUWB  = 16'b0_0_0_1_0_1_0_00_000_00_0_0;
  localparam logic [15:0] ADDIWB = 16'b0_0_0_0_0_1_0_00_000_00_0_0;
  localparam logic [15:0] BR_T   = 16'b0_0_0_0_0_0_1_00_001_01_1_0;
  localparam logic [15:0] BR_N   = 16'b0_0_0_0_0_0_1_00_001_01_0_0;
  localparam logic [15:0] JMP    = 16'b0_0_0_0_0_0_0_00_000_10_1_0;
  typedef struct {
    string name;
    logic [15:0] exp;
  } item_t;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic [15:0] ov [3];
  int sel = 0, tests = 0, fails = 0;
  item_t q[$];
  item_t it;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic iord, mw, irw, rd, m2r, rw, sa, pce, ill;
    logic [1:0] sb, pcs;
    logic [2:0] ctl;
    mips_multicycle_ctrl #(.MEM_LATENCY(g + 1)) dut (
      .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Zero(zero),
      .IorD(iord), .MemWrite(mw), .IRWrite(irw), .RegDst(rd), .MemtoReg(m2r),
      .RegWrite(rw), .ALUSrcA(sa), .ALUSrcB(sb), .ALUCtl(ctl), .PCSrc(pcs),
      .PCEn(pce), .illegal_op(ill)
    );
    assign ov[g] = {iord, mw, irw, rd, m2r, rw, sa, sb, ctl, pcs, pce, ill};
  end
  always @(negedge clk)
    if (q.size() > 0) begin
      it = q.pop_front();
      tests++;
      if (ov[sel] !== it.exp) begin
        fails++;
        $display("FAIL %s (lat %0d): got %b want %b", it.name, sel + 1, ov[sel], it.exp);
      end
    end
  task automatic cyc(input string n, input logic [15:0] e);
    q.push_back('{n, e});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int s);
    sel = s;
    reset = 1'b1;
    #1;
    tests++;
    if (ov[sel] !== ZERO) begin
      fails++;
      $display("FAIL async reset state (lat %0d): got %b want %b", sel + 1, ov[sel], ZERO);
    end
    cyc("reset", ZERO);
    cyc("reset_hold", ZERO);
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    @(posedge clk);
    #1;
    do_reset(0);
    op = 6'b100011;
    cyc("lw_f", F_L); cyc("lw_d", DEC); cyc("lw_ma", MA); cyc("lw_mr", MR); cyc("lw_wb", MWB);
    op = 6'b000000; funct = 6'b101010;
    cyc("slt_f", F_L); cyc("slt_d", DEC); cyc("slt_ex", EX_SLT); cyc("slt_wb", ALUWB);
    funct = 6'b111111;
    cyc("rbad_f", F_L); cyc("rbad_d", DEC); cyc("rbad_ex", EX_ADD); cyc("rbad_wb", ALUWB);
    funct = 6'b100010;
    cyc("sub_f", F_L); cyc("sub_d", DEC); cyc("sub_ex", EX_SUB); cyc("sub_wb", ALUWB);
    funct = 6'b100101;
    cyc("or_f", F_L); cyc("or_d", DEC); cyc("or_ex", EX_OR); cyc("or_wb", ALUWB);
    op = 6'b001000;
    cyc("addi_f", F_L); cyc("addi_d", DEC); cyc("addi_ex", MA); cyc("addi_wb", ADDIWB);
    op = 6'b000100; zero = 1'b1;
    cyc("beq1_f", F_L); cyc("beq1_d", DEC); cyc("beq1_br", BR_T);
    zero = 1'b0;
    cyc("beq0_f", F_L); cyc("beq0_d", DEC); cyc("beq0_br", BR_N);
    op = 6'b000010;
    cyc("j_f", F_L); cyc("j_d", DEC); cyc("j_j", JMP);
    op = 6'b111111;
    cyc("ill_f", F_L); cyc("ill_d", DEC_IL); cyc("ill_next_f", F_L); cyc("ill_next_d", DEC_IL);
    op = 6'b100011;
    cyc("lwchg_f", F_L); cyc("lwchg_d", DEC);
    op = 6'b101011;
    cyc("lwchg_ma", MA); cyc("lwchg_mr", MR); cyc("lwchg_wb", MWB);
    cyc("sw_f", F_L); cyc("sw_d", DEC); cyc("sw_ma", MA); cyc("sw_mw", MW_L); cyc("sw_next_f", F_L);
    do_reset(1);
    op = 6'b100011;
    cyc("l2_f1", F_W); cyc("l2_f2", F_L); cyc("l2_d", DEC); cyc("l2_ma", MA); cyc("l2_mr1", MR);
    reset = 1'b1;
    cyc("l2_mr2_reset", ZERO);
    reset = 1'b0;
    cyc("l2_after_f1", F_W); cyc("l2_after_f2", F_L); cyc("l2_after_d", DEC);
    do_reset(2);
    op = 6'b101011;
    cyc("s3_f1", F_W); cyc("s3_f2", F_W); cyc("s3_f3", F_L); cyc("s3_d", DEC); cyc("s3_ma", MA);
    cyc("s3_mw1", MW_W); cyc("s3_mw2", MW_W); cyc("s3_mw3", MW_L); cyc("s3_next_f1", F_W);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL wait expired with %0d expectations unchecked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
